matmul_tile_sequencer: RTL and testbench

// - Parametrised tiling sequencer for the MxM systolic array. Walks C[K1xK3] = A[K1xK2] * W[K2xK3] in MxM tiles.
// - Issues A/W tile read requests with zero-pad flags, compute handshakes and C write-back requests.
// - Supports weight-stationary and output-stationary modes.
// - Sits between Control's start/done interface and the memory/tile buffers; replaces fixed-size tile loops.

---
 rtl/matmul_tile_sequencer_if.sv | 29 ++
 rtl/matmul_tile_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_matmul_tile_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_tile_sequencer_if.sv
// rtl/matmul_tile_sequencer_if.sv - read/compute/write handshake bundle between the tile sequencer and the array side
interface matmul_tile_sequencer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int IDX_WIDTH  = 4
);
  logic                  rd_valid;
  logic                  rd_ready;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_sel;
  logic                  rd_pad;
  logic [IDX_WIDTH-1:0]  rd_idx;
  logic                  cmp_start;
  logic                  cmp_done;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [IDX_WIDTH-1:0]  wr_idx;
  logic                  wr_accum;

  modport master (
    output rd_valid, rd_addr, rd_sel, rd_pad, rd_idx, cmp_start, wr_valid, wr_addr, wr_idx, wr_accum,
    input  rd_ready, cmp_done, wr_ready
  );

  modport slave (
    input  rd_valid, rd_addr, rd_sel, rd_pad, rd_idx, cmp_start, wr_valid, wr_addr, wr_idx, wr_accum,
    output rd_ready, cmp_done, wr_ready
  );
endinterface

// File: rtl/matmul_tile_sequencer.sv
// rtl/matmul_tile_sequencer.sv - MxM tile walker for C = A*W (WS/OS); TILE_SEQ_PERF_EN adds perf counters
module matmul_tile_sequencer #(
  parameter int M          = 3,
  parameter int ADDR_WIDTH = 16,
  parameter int DIM_WIDTH  = 8,
  parameter int WORD_BYTES = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DIM_WIDTH-1:0]  K1,
  input  logic [DIM_WIDTH-1:0]  K2,
  input  logic [DIM_WIDTH-1:0]  K3,
  input  logic [ADDR_WIDTH-1:0] A_base_addr,
  input  logic [ADDR_WIDTH-1:0] W_base_addr,
  input  logic [ADDR_WIDTH-1:0] C_base_addr,
  input  logic                  output_stationary,
  output logic                  busy,
  output logic                  done,
`ifdef TILE_SEQ_PERF_EN
  output logic [31:0]           perf_cycles,
  output logic [31:0]           perf_stalls,
`endif
  matmul_tile_sequencer_if.master bus
);
  localparam int IDX_W = $clog2(M*M);
  localparam logic [IDX_W-1:0] RC_LAST = IDX_W'(M-1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_W, S_COMPUTE, S_STORE, S_NEXT, S_FIN} state_t;
  state_t state, state_nxt;

  logic [DIM_WIDTH-1:0]  k1, k2, k3, ti, tj, tk;
  logic [ADDR_WIDTH-1:0] a_base, w_base, c_base, rbase, rd_off, wr_off;
  logic                  os, zero_k, cmp_sent;
  logic [IDX_W-1:0]      r, c, idx;
  logic [31:0]           nt2, nt3, nt1, row, col, rdim, cdim, stride, wrow, wcol;
  logic                  pad, last_rc, last_wr_row, last_wr_col, last_tk, last_tj, last_ti;
  logic                  rd_valid_i, cmp_start_i, wr_valid_i, wr_accum_i;

  // Tile geometry: A tile reads (ti,tk), W tile reads (tk,tj), C tile writes (ti,tj)
  always_comb begin
    nt1 = (32'(k1) + 32'(M-1)) / 32'(M);
    nt2 = (32'(k2) + 32'(M-1)) / 32'(M);
    nt3 = (32'(k3) + 32'(M-1)) / 32'(M);
    if (state == S_LOAD_W) begin
      row    = 32'(tk) * 32'(M) + 32'(r);
      col    = 32'(tj) * 32'(M) + 32'(c);
      rdim   = 32'(k2);
      cdim   = 32'(k3);
      stride = 32'(k3);
      rbase  = w_base;
    end else begin
      row    = 32'(ti) * 32'(M) + 32'(r);
      col    = 32'(tk) * 32'(M) + 32'(c);
      rdim   = 32'(k1);
      cdim   = 32'(k2);
      stride = 32'(k2);
      rbase  = a_base;
    end
    pad         = (row >= rdim) || (col >= cdim);
    rd_off      = ADDR_WIDTH'((row * stride + col) * 32'(WORD_BYTES));
    wrow        = 32'(ti) * 32'(M) + 32'(r);
    wcol        = 32'(tj) * 32'(M) + 32'(c);
    wr_off      = ADDR_WIDTH'((wrow * 32'(k3) + wcol) * 32'(WORD_BYTES));
    idx         = IDX_W'(32'(r) * 32'(M) + 32'(c));
    last_rc     = (r == RC_LAST) && (c == RC_LAST);
    // Store walk covers only the in-range rectangle, so skipped elements cost no cycles
    last_wr_row = (r == RC_LAST) || (wrow + 32'd1 >= 32'(k1));
    last_wr_col = (c == RC_LAST) || (wcol + 32'd1 >= 32'(k3));
    last_tk     = (32'(tk) + 32'd1 >= nt2);
    last_tj     = (32'(tj) + 32'd1 >= nt3);
    last_ti     = (32'(ti) + 32'd1 >= nt1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    rd_valid_i  = 1'b0;
    cmp_start_i = 1'b0;
    wr_valid_i  = 1'b0;
    wr_accum_i  = 1'b0;
    busy        = (state != S_IDLE) && (state != S_FIN);
    done        = (state == S_FIN);
    case (state)
      S_IDLE: begin
        if (start) begin
          if (K1 == '0 || K2 == '0 || K3 == '0) state_nxt = S_NEXT;
          else                                  state_nxt = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        rd_valid_i = 1'b1;
        if (bus.rd_ready && last_rc) state_nxt = S_LOAD_W;
      end
      S_LOAD_W: begin
        rd_valid_i = 1'b1;
        if (bus.rd_ready && last_rc) state_nxt = S_COMPUTE;
      end
      S_COMPUTE: begin
        cmp_start_i = !cmp_sent;
        if (cmp_sent && bus.cmp_done) state_nxt = (!os || last_tk) ? S_STORE : S_NEXT;
      end
      S_STORE: begin
        wr_valid_i = 1'b1;
        wr_accum_i = !os && (tk != '0);
        if (bus.wr_ready && last_wr_row && last_wr_col) state_nxt = S_NEXT;
      end
      S_NEXT: begin
        if (zero_k || (last_ti && last_tj && last_tk)) state_nxt = S_FIN;
        else                                           state_nxt = S_LOAD_A;
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.rd_valid  = rd_valid_i;
  assign bus.rd_sel    = (state == S_LOAD_W);
  assign bus.rd_pad    = rd_valid_i && pad;
  assign bus.rd_addr   = (rd_valid_i && !pad) ? rbase + rd_off : '0;
  assign bus.rd_idx    = rd_valid_i ? idx : '0;
  assign bus.cmp_start = cmp_start_i;
  assign bus.wr_valid  = wr_valid_i;
  assign bus.wr_accum  = wr_accum_i;
  assign bus.wr_addr   = wr_valid_i ? c_base + wr_off : '0;
  assign bus.wr_idx    = wr_valid_i ? idx : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k1 <= '0; k2 <= '0; k3 <= '0;
      ti <= '0; tj <= '0; tk <= '0;
      r <= '0; c <= '0;
      a_base <= '0; w_base <= '0; c_base <= '0;
      os <= 1'b0; zero_k <= 1'b0; cmp_sent <= 1'b0;
    end else begin
      cmp_sent <= (state == S_COMPUTE) && (state_nxt == S_COMPUTE);
      case (state)
        S_IDLE: begin
          if (start) begin
            k1     <= K1;
            k2     <= K2;
            k3     <= K3;
            a_base <= A_base_addr;
            w_base <= W_base_addr;
            c_base <= C_base_addr;
            os     <= output_stationary;
            zero_k <= (K1 == '0) || (K2 == '0) || (K3 == '0);
            ti <= '0; tj <= '0; tk <= '0;
            r  <= '0; c  <= '0;
          end
        end
        S_LOAD_A, S_LOAD_W: begin
          if (bus.rd_ready) begin
            if (c == RC_LAST) begin
              c <= '0;
              r <= (r == RC_LAST) ? '0 : r + IDX_W'(1);
            end else begin
              c <= c + IDX_W'(1);
            end
          end
        end
        S_STORE: begin
          if (bus.wr_ready) begin
            if (last_wr_col) begin
              c <= '0;
              r <= last_wr_row ? '0 : r + IDX_W'(1);
            end else begin
              c <= c + IDX_W'(1);
            end
          end
        end
        S_NEXT: begin
          if (last_tk) begin
            tk <= '0;
            if (last_tj) begin
              tj <= '0;
              ti <= ti + DIM_WIDTH'(1);
            end else begin
              tj <= tj + DIM_WIDTH'(1);
            end
          end else begin
            tk <= tk + DIM_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TILE_SEQ_PERF_EN
  logic stall;
  assign stall = (rd_valid_i && !bus.rd_ready) || (wr_valid_i && !bus.wr_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (state == S_IDLE && start) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else begin
      if (busy && perf_cycles != '1)  perf_cycles <= perf_cycles + 32'd1;
      if (stall && perf_stalls != '1) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// tb/tb_matmul_tile_sequencer.sv - scoreboard bench for matmul_tile_sequencer
module tb_matmul_tile_sequencer;
  localparam int M = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        os = 1'b0;
  logic [7:0]  k1 = 8'd5, k2 = 8'd5, k3 = 8'd5;
  logic [15:0] a_base = 16'd0, w_base = 16'd512, c_base = 16'd1024;
  logic        busy, done;
`ifdef TILE_SEQ_PERF_EN
  logic [31:0] perf_cycles, perf_stalls;
`endif

  int checks = 0, failures = 0;
  int rd_cnt = 0, wr_cnt = 0, acc0_cnt = 0, acc1_cnt = 0, cmp_cnt = 0, done_cnt = 0;
  int cd = 0;
  bit seen_a44 = 0, seen_c44 = 0, rd_toggle = 0, prev_stall = 0;
  logic [31:0] held = 0, obs, exp_v;
  logic [31:0] rd_q[$];
  logic [31:0] wr_q[$];

  matmul_tile_sequencer_if #(.ADDR_WIDTH(16), .IDX_WIDTH(4)) bus ();

  matmul_tile_sequencer #(.M(3), .ADDR_WIDTH(16), .DIM_WIDTH(8), .WORD_BYTES(8)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .K1                (k1),
    .K2                (k2),
    .K3                (k3),
    .A_base_addr       (a_base),
    .W_base_addr       (w_base),
    .C_base_addr       (c_base),
    .output_stationary (os),
    .busy              (busy),
    .done              (done),
`ifdef TILE_SEQ_PERF_EN
    .perf_cycles       (perf_cycles),
    .perf_stalls       (perf_stalls),
`endif
    .bus               (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] observed, logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic push_job(int a1, int a2, int a3, int ab, int wb, int cb, bit o);
    int n1, n2, n3, row, col, addr;
    bit pad, acc;
    if (a1 == 0 || a2 == 0 || a3 == 0) return;
    n1 = (a1 + M - 1) / M;
    n2 = (a2 + M - 1) / M;
    n3 = (a3 + M - 1) / M;
    for (int ti = 0; ti < n1; ti++)
      for (int tj = 0; tj < n3; tj++)
        for (int tk = 0; tk < n2; tk++) begin
          for (int i = 0; i < M*M; i++) begin
            row = ti*M + i/M; col = tk*M + i%M;
            pad = (row >= a1) || (col >= a2);
            addr = pad ? 0 : ((ab + (row*a2 + col)*8) & 32'hFFFF);
            rd_q.push_back({10'b0, 1'b0, pad, 4'(i), 16'(addr)});
          end
          for (int i = 0; i < M*M; i++) begin
            row = tk*M + i/M; col = tj*M + i%M;
            pad = (row >= a2) || (col >= a3);
            addr = pad ? 0 : ((wb + (row*a3 + col)*8) & 32'hFFFF);
            rd_q.push_back({10'b0, 1'b1, pad, 4'(i), 16'(addr)});
          end
          if (!o || tk == n2 - 1) begin
            acc = !o && (tk != 0);
            for (int i = 0; i < M*M; i++) begin
              row = ti*M + i/M; col = tj*M + i%M;
              if (row < a1 && col < a3) begin
                addr = (cb + (row*a3 + col)*8) & 32'hFFFF;
                wr_q.push_back({11'b0, acc, 4'(i), 16'(addr)});
              end
            end
          end
        end
  endtask

  // Responder and scoreboard checker, evaluated on the falling edge
  always @(negedge clk) begin
    if (!reset_n) begin
      cd = 0;
      bus.cmp_done = 1'b0;
      prev_stall = 0;
    end else begin
      if (rd_toggle) bus.rd_ready = ~bus.rd_ready;
      if (cd > 0) begin
        cd--;
        bus.cmp_done = (cd == 0);
      end else begin
        bus.cmp_done = 1'b0;
      end
      if (bus.cmp_start) begin
        cmp_cnt++;
        cd = 4;
      end
      obs = {10'b0, bus.rd_sel, bus.rd_pad, bus.rd_idx, bus.rd_addr};
      if (prev_stall && bus.rd_valid) chk("rd_stable", obs, held);
      prev_stall = bus.rd_valid && !bus.rd_ready;
      held = obs;
      if (bus.rd_valid && bus.rd_ready) begin
        rd_cnt++;
        exp_v = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hFFFF_FFFF;
        chk("rd_beat", obs, exp_v);
        if (obs == {10'b0, 1'b0, 1'b0, 4'd4, 16'd192}) seen_a44 = 1;
      end
      if (bus.wr_valid && bus.wr_ready) begin
        wr_cnt++;
        if (bus.wr_accum) acc1_cnt++; else acc0_cnt++;
        obs = {11'b0, bus.wr_accum, bus.wr_idx, bus.wr_addr};
        exp_v = (wr_q.size() > 0) ? wr_q.pop_front() : 32'hFFFF_FFFF;
        chk("wr_beat", obs, exp_v);
        if (bus.wr_addr == 16'd1216 && bus.wr_idx == 4'd4) seen_c44 = 1;
      end
      if (done) begin
        done_cnt++;
        chk("busy_with_done", {31'b0, busy}, 0);
      end
    end
  end

  task automatic clear_stats();
    rd_cnt = 0; wr_cnt = 0; acc0_cnt = 0; acc1_cnt = 0; cmp_cnt = 0; done_cnt = 0;
    seen_a44 = 0; seen_c44 = 0;
  endtask

  task automatic start_job(int a1, int a2, int a3, bit o);
    k1 = 8'(a1); k2 = 8'(a2); k3 = 8'(a3); os = o;
    push_job(a1, a2, a3, a_base, w_base, c_base, o);
    clear_stats();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("busy_after_start", {31'b0, busy}, 1);
  endtask

  task automatic wait_done(int bound);
    int n = 0;
    while (done_cnt == 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    chk("done_pulses", done_cnt, 1);
    chk("busy_after_done", {31'b0, busy}, 0);
  endtask

  task automatic check_counts(string tag, int rd, int cmp, int wr, int a0, int a1);
    chk({tag, "_rd"}, rd_cnt, rd);
    chk({tag, "_cmp"}, cmp_cnt, cmp);
    chk({tag, "_wr"}, wr_cnt, wr);
    chk({tag, "_acc0"}, acc0_cnt, a0);
    chk({tag, "_acc1"}, acc1_cnt, a1);
    chk({tag, "_rdq"}, rd_q.size(), 0);
    chk({tag, "_wrq"}, wr_q.size(), 0);
  endtask

  initial begin
    bus.rd_ready = 1'b1;
    bus.wr_ready = 1'b1;
    bus.cmp_done = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_ctrl", {26'b0, busy, done, bus.rd_valid, bus.cmp_start, bus.wr_valid, bus.wr_accum}, 0);
    chk("rst_addr", {bus.rd_addr, bus.wr_addr}, 0);
    chk("rst_idx", {24'b0, bus.rd_idx, bus.wr_idx}, 0);
    @(posedge clk); #2 reset_n = 1'b1;

    // Weight-stationary, full-speed handshakes
    start_job(5, 5, 5, 1'b0);
    wait_done(3000);
    check_counts("ws", 144, 8, 50, 25, 25);
    chk("a44_addr_seen", {31'b0, seen_a44}, 1);

    // Output-stationary
    start_job(5, 5, 5, 1'b1);
    wait_done(3000);
    check_counts("os", 144, 8, 25, 25, 0);
    chk("c44_addr_seen", {31'b0, seen_c44}, 1);

    // Stalling reads, plus a start pulse while busy that must be ignored
    @(posedge clk);
    rd_toggle = 1;
    start_job(5, 5, 5, 1'b0);
    repeat (30) @(negedge clk);
    k1 = 8'd1; k2 = 8'd1; k3 = 8'd1; os = 1'b1;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(5000);
    check_counts("stall", 144, 8, 50, 25, 25);
    @(posedge clk);
    rd_toggle = 0;
    bus.rd_ready = 1'b1;

    // Zero dimension: one busy cycle, then done
    clear_stats();
    k1 = 8'd5; k2 = 8'd0; k3 = 8'd5; os = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    chk("zk_busy_c1", {30'b0, busy, done}, 32'd2);
    k2 = 8'd5;
    @(negedge clk) start = 1'b0;
    chk("zk_done_c2", {30'b0, busy, done}, 32'd1);
    @(negedge clk);
    chk("zk_idle_c3", {30'b0, busy, done}, 32'd0);
    repeat (3) @(posedge clk);
    chk("zk_activity", rd_cnt + cmp_cnt + wr_cnt, 0);

    // Reset while loading W, then a clean rerun
    start_job(5, 5, 5, 1'b0);
    for (int n = 0; n < 200 && !(bus.rd_valid && bus.rd_sel); n++) @(negedge clk);
    chk("reached_load_w", {31'b0, bus.rd_sel}, 1);
    @(posedge clk); #2 reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_ctrl", {26'b0, busy, done, bus.rd_valid, bus.cmp_start, bus.wr_valid, bus.wr_accum}, 0);
    chk("mid_rst_addr", {bus.rd_addr, bus.wr_addr}, 0);
    repeat (3) @(posedge clk);
    chk("mid_rst_no_done", done_cnt, 0);
    rd_q.delete();
    wr_q.delete();
    #2 reset_n = 1'b1;
    start_job(5, 5, 5, 1'b0);
    wait_done(3000);
    check_counts("rerun", 144, 8, 50, 25, 25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
